// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, segment bit order
// and the active-low hex decode table.
package seg7_pkg;

   // Segment vector order is {a,b,c,d,e,f,g}, segment a in the MSB; all patterns active-low
   localparam int SEG_A_BIT = 6;
   localparam int SEG_G_BIT = 0;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = seg_decode(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with shadowed display word.
// Optional leading-zero blanking is built when SEG7_LEAD_ZERO_BLANK_EN is defined.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 100000
)
(
   input  logic                  clk100_i,
   input  logic                  rstn_i,
   input  logic [4*DIGITS-1:0]   data_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic [DIGITS-1:0]     en_i,
   input  logic                  load_i,
   output logic [6:0]            hex_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  frame_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [PW-1:0]        presc_q, presc_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [4*DIGITS-1:0]  data_q;
   logic [DIGITS-1:0]    dp_sh_q;
   logic [DIGITS-1:0]    en_q;
   logic [DIGITS-1:0]    show;
   logic                 tick;
   logic                 wrap;
   logic                 active;
   logic [3:0]           nib;
   logic [6:0]           seg;
   logic [DIGITS-1:0]    an_q, an_d;
   logic [6:0]           hex_q, hex_d;
   logic                 dpo_q, dpo_d;

   assign tick = (presc_q == PRESC_MAX);
   assign wrap = tick && (idx_q == IDX_MAX);

   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      idx_d   = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + IW'(1);
      end
   end

   // Which digits may light: enable mask, optionally masked by leading-zero detect
`ifdef SEG7_LEAD_ZERO_BLANK_EN
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_d0
         assign show[gi] = en_q[gi];
      end else begin : g_dn
         assign show[gi] = en_q[gi] & (|data_q[4*DIGITS-1:4*gi]);
      end
   end
`else
   assign show = en_q;
`endif

   assign nib    = data_q[{idx_q, 2'b00} +: 4];
   assign active = show[idx_q];

   seg7_hex_decoder u_dec (
      .nib_i (nib),
      .seg_o (seg)
   );

   always_comb begin
      an_d  = '1;
      hex_d = SEG_BLANK;
      dpo_d = 1'b1;
      if (active) begin
         an_d  = ~(DIGITS'(1) << idx_q);
         hex_d = seg;
         dpo_d = ~dp_sh_q[idx_q];
      end
   end

   always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
         presc_q <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         dp_sh_q <= '0;
         en_q    <= '0;
         an_q    <= '1;
         hex_q   <= SEG_BLANK;
         dpo_q   <= 1'b1;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         if (load_i) begin
            data_q  <= data_i;
            dp_sh_q <= dp_i;
            en_q    <= en_i;
         end
         an_q  <= an_d;
         hex_q <= hex_d;
         dpo_q <= dpo_d;
      end
   end

   assign an_o  = an_q;
   assign hex_o = hex_q;
   assign dp_o  = dpo_q;
   // With SCAN_DIV=1 the tick is permanently true, so gate by reset to keep frame_o low in reset
   assign frame_o = wrap & rstn_i;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected output changes and frame pulses are queued
// with their cycle stamps; a monitor pops and compares whenever the display outputs change.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] data;
   logic [7:0]  dp, en;
   logic        load;
   logic [6:0]  hex;
   logic        dpo;
   logic [7:0]  an;
   logic        frame;

   logic [3:0]  data1;
   logic        dp1, en1, load1;
   logic [6:0]  hex1;
   logic        dpo1;
   logic        an1;
   logic        frame1;

   int cyc;
   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int         cyc;
      logic [7:0] an;
      logic [6:0] hex;
      logic       dp;
   } ev_t;

   ev_t exp_q[$];
   int  frame_q[$];

   logic [6:0] seg_ref [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   seg7_scan_driver #(.DIGITS(8), .SCAN_DIV(4)) dut (
      .clk100_i (clk),
      .rstn_i   (rstn),
      .data_i   (data),
      .dp_i     (dp),
      .en_i     (en),
      .load_i   (load),
      .hex_o    (hex),
      .dp_o     (dpo),
      .an_o     (an),
      .frame_o  (frame)
   );

   seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(1)) dut1 (
      .clk100_i (clk),
      .rstn_i   (rstn),
      .data_i   (data1),
      .dp_i     (dp1),
      .en_i     (en1),
      .load_i   (load1),
      .hex_o    (hex1),
      .dp_o     (dpo1),
      .an_o     (an1),
      .frame_o  (frame1)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, req);
      end else begin
         $display("ok   %s: cycle %0d value %h", name, cyc, act);
      end
   endtask

   task automatic push_dig(input int c, input int k, input int nib, input logic lit);
      ev_t e;
      e.cyc = c;
      e.an  = ~(8'h01 << k);
      e.hex = seg_ref[nib];
      e.dp  = ~lit;
      exp_q.push_back(e);
   endtask

   task automatic push_blank(input int c);
      ev_t e;
      e.cyc = c;
      e.an  = 8'hFF;
      e.hex = 7'b1111111;
      e.dp  = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic release_rst();
      @(negedge clk);
      #2 rstn = 1'b1;
   endtask

   // Assert reset between edges and check the outputs go idle without waiting for a clock
   task automatic reset_now();
      #2 rstn = 1'b0;
      #1;
      check("rst_an_o",     an,     8'hFF);
      check("rst_hex_o",    hex,    7'h7F);
      check("rst_dp_o",     dpo,    1'b1);
      check("rst_frame_o",  frame,  1'b0);
      check("rst1_an_o",    an1,    1'b1);
      check("rst1_frame_o", frame1, 1'b0);
   endtask

   task automatic end_phase(input string name);
      check({name, "_events_pending"}, exp_q.size(), 0);
      check({name, "_frames_pending"}, frame_q.size(), 0);
      exp_q.delete();
      frame_q.delete();
   endtask

   // Monitor: compares on every display change, every frame pulse, and every DIGITS=1 cycle
   initial begin
      logic [15:0] prev;
      logic [15:0] cur;
      ev_t         e;
      int          fc;
      prev = '1;
      forever begin
         @(negedge clk);
         cur = {an, hex, dpo};
         if (!rstn) begin
            prev = cur;
         end else begin
            if (cur !== prev) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_change: cycle %0d got an=%h hex=%b dp=%b, required no change",
                           cyc, an, hex, dpo);
               end else begin
                  e = exp_q.pop_front();
                  check("change_cycle", cyc, e.cyc);
                  check("an_o", an, e.an);
                  check("hex_o", hex, e.hex);
                  check("dp_o", dpo, e.dp);
               end
            end
            prev = cur;
            if (frame) begin
               if (frame_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_frame: cycle %0d got frame_o=1, required 0", cyc);
               end else begin
                  fc = frame_q.pop_front();
                  check("frame_cycle", cyc, fc);
               end
            end
            if (cyc >= 2) begin
               check("d1_an_o",    an1,    1'b0);
               check("d1_hex_o",   hex1,   seg_ref[12]);
               check("d1_dp_o",    dpo1,   1'b0);
               check("d1_frame_o", frame1, 1'b1);
            end else if (cyc == 1) begin
               check("d1_an_o_first",    an1,    1'b1);
               check("d1_frame_o_first", frame1, 1'b1);
            end
         end
      end
   end

   initial begin
      rstn  = 1'b0;
      load  = 1'b0;
      data  = '0;
      dp    = '0;
      en    = '0;
      data1 = 4'hC;
      dp1   = 1'b1;
      en1   = 1'b1;
      load1 = 1'b1;
      repeat (3) @(negedge clk);

      // Full hex walk, then reset mid-scan while digit 5 is shown
      data = 32'h89ABCDEF;
      en   = 8'hFF;
      dp   = 8'h00;
      load = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 8; k++) begin
            int c;
            c = (f == 0 && k == 0) ? 2 : 32 * f + 4 * k + 1;
            if (c <= 87) push_dig(c, k, 15 - k, 1'b0);
         end
      end
      frame_q.push_back(31);
      frame_q.push_back(63);
      release_rst();
      wait_cyc(1);
      #2 load = 1'b0;
      data = 32'h12345678;
      en   = 8'h00;
      dp   = 8'hFF;
      wait_cyc(87);
      reset_now();
      end_phase("walk");

      // Partial enable with one decimal point, then reload zeros during the digit 2 slot
      data = 32'h89ABCDEF;
      en   = 8'h0F;
      dp   = 8'h01;
      load = 1'b1;
      push_dig(2, 0, 15, 1'b1);
      push_dig(5, 1, 14, 1'b0);
      push_dig(9, 2, 13, 1'b0);
      push_dig(13, 3, 12, 1'b0);
      push_blank(17);
      push_dig(33, 0, 15, 1'b1);
      push_dig(37, 1, 14, 1'b0);
      push_dig(41, 2, 13, 1'b0);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      push_blank(43);
      push_dig(65, 0, 0, 1'b1);
      push_blank(69);
      push_dig(97, 0, 0, 1'b1);
`else
      push_dig(43, 2, 0, 1'b0);
      push_dig(45, 3, 0, 1'b0);
      push_blank(49);
      push_dig(65, 0, 0, 1'b1);
      push_dig(69, 1, 0, 1'b0);
      push_dig(73, 2, 0, 1'b0);
      push_dig(77, 3, 0, 1'b0);
      push_blank(81);
      push_dig(97, 0, 0, 1'b1);
`endif
      frame_q.push_back(31);
      frame_q.push_back(63);
      frame_q.push_back(95);
      release_rst();
      wait_cyc(1);
      #2 load = 1'b0;
      wait_cyc(41);
      #2 data = 32'h00000000;
      load = 1'b1;
      wait_cyc(42);
      #2 load = 1'b0;
      wait_cyc(100);
      reset_now();
      end_phase("mask_reload");

      // Small value with leading zeros
      data = 32'h00000120;
      en   = 8'hFF;
      dp   = 8'h00;
      load = 1'b1;
      push_dig(2, 0, 0, 1'b0);
      push_dig(5, 1, 2, 1'b0);
      push_dig(9, 2, 1, 1'b0);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      push_blank(13);
`else
      push_dig(13, 3, 0, 1'b0);
      push_dig(17, 4, 0, 1'b0);
      push_dig(21, 5, 0, 1'b0);
      push_dig(25, 6, 0, 1'b0);
      push_dig(29, 7, 0, 1'b0);
`endif
      push_dig(33, 0, 0, 1'b0);
      push_dig(37, 1, 2, 1'b0);
      frame_q.push_back(31);
      release_rst();
      wait_cyc(1);
      #2 load = 1'b0;
      wait_cyc(40);
      end_phase("lead_zero");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
